// File: rtl/mem_copy_if.sv
// Memory request/response types and the initiator<->RAM interface for mem_copy.
// mem_in_type is what the RAM receives; mem_out_type is what it returns.
package mem_copy_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic        mem_error;
  } mem_out_type;

endpackage

interface mem_copy_if;
  import mem_copy_pkg::*;

  mem_in_type  mem_out;
  mem_out_type mem_in;

  modport master (output mem_out, input mem_in);
  modport slave  (input mem_out, output mem_in);
endinterface

// File: rtl/mem_copy.sv
// mem_copy: block-copy engine, LENGTH doublewords from src to dst, one access
// outstanding at a time. Optional per-access ready timeout is enabled with
// the MEM_COPY_TIMEOUT_EN macro (TIMEOUT sets the limit in waiting cycles).
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | waiting for start
// RD_REQ  | read request on the bus (mem_valid high)
// RD_WAIT | waiting for read response
// WR_REQ  | write request on the bus with the read data
// WR_WAIT | waiting for write response, then advance pointers
// DONE    | done pulse, back to IDLE
// FAIL    | error raised (sticky), back to IDLE
module mem_copy
  import mem_copy_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] length,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] count,
  mem_copy_if.master  mem
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE, FAIL
  } state_t;

  state_t      state_q;
  logic [31:0] src_q, dst_q;
  logic [15:0] len_q, count_q;
  logic        busy_q, done_q, error_q;
  mem_in_type  req_q;

  logic [15:0] count_d;
  logic [31:0] src_d, dst_d;
  logic [31:0] src_start_d, dst_start_d;

  // Byte offsets inside a doubleword are meaningless for this engine.
  logic [5:0] unused_lsb;
  assign unused_lsb = {src_addr[2:0], dst_addr[2:0]};

`ifdef MEM_COPY_TIMEOUT_EN
  logic [31:0] wait_q;
  logic        wait_expire_d;
  // The waiting cycle that would bring the counter to TIMEOUT is the last one.
  assign wait_expire_d = ((wait_q + 32'd1) == 32'(TIMEOUT));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  // Pointer/count increments and aligned start addresses.
  always_comb begin
    count_d     = count_q + 16'd1;
    src_d       = src_q + 32'd8;
    dst_d       = dst_q + 32'd8;
    src_start_d = {src_addr[31:3], 3'b000};
    dst_start_d = {dst_addr[31:3], 3'b000};
  end

  // Copy sequencer; every output comes straight from a register here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      req_q   <= '0;
`ifdef MEM_COPY_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            src_q   <= src_start_d;
            dst_q   <= dst_start_d;
            len_q   <= length;
            count_q <= '0;
            error_q <= 1'b0;
            if (length == 16'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= RD_REQ;
              busy_q  <= 1'b1;
              req_q   <= '{mem_valid: 1'b1, mem_addr: src_start_d,
                           mem_wdata: 64'd0, mem_wstrb: 8'h00};
            end
          end
        end
        RD_REQ: begin
          req_q   <= '0;
          state_q <= RD_WAIT;
`ifdef MEM_COPY_TIMEOUT_EN
          wait_q  <= '0;
`endif
        end
        RD_WAIT: begin
          if (mem.mem_in.mem_ready) begin
            if (mem.mem_in.mem_error) begin
              state_q <= FAIL;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              // The write request register doubles as the data buffer.
              state_q <= WR_REQ;
              req_q   <= '{mem_valid: 1'b1, mem_addr: dst_q,
                           mem_wdata: mem.mem_in.mem_rdata, mem_wstrb: 8'hFF};
            end
          end
`ifdef MEM_COPY_TIMEOUT_EN
          else if (wait_expire_d) begin
            state_q <= FAIL;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
`endif
        end
        WR_REQ: begin
          req_q   <= '0;
          state_q <= WR_WAIT;
`ifdef MEM_COPY_TIMEOUT_EN
          wait_q  <= '0;
`endif
        end
        WR_WAIT: begin
          if (mem.mem_in.mem_ready) begin
            if (mem.mem_in.mem_error) begin
              state_q <= FAIL;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              count_q <= count_d;
              src_q   <= src_d;
              dst_q   <= dst_d;
              if (count_d == len_q) begin
                state_q <= DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q <= RD_REQ;
                req_q   <= '{mem_valid: 1'b1, mem_addr: src_d,
                             mem_wdata: 64'd0, mem_wstrb: 8'h00};
              end
            end
          end
`ifdef MEM_COPY_TIMEOUT_EN
          else if (wait_expire_d) begin
            state_q <= FAIL;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
`endif
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        FAIL: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_out = req_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign count       = count_q;

endmodule

// File: tb/tb_mem_copy.sv
// Testbench for mem_copy: RAM responder with configurable latency and error
// injection, a sequential reference model of the copy, a directed vector
// table, random runs and hand-written reset/timeout sequences.
module tb_mem_copy;
  import mem_copy_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] length = '0;
  logic        busy, done, error;
  logic [15:0] count;

  mem_copy_if mif ();

  mem_copy #(.TIMEOUT(32)) dut (
    .clock(clock), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .error(error), .count(count),
    .mem(mif)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    int          lat;
    int          err_rd;
    int          err_wr;
    bit          extra;
    int          exp_cnt;
    bit          exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  s;
    logic [63:0] d;
  } acc_t;

  int checks = 0;
  int errors = 0;

  logic [63:0] ram [bit [31:0]];
  logic [63:0] mdl [bit [31:0]];
  acc_t exp_q[$];
  acc_t act_q[$];

  int rsp_lat = 1;
  int err_rd  = 0;
  int err_wr  = 0;
  int rd_n    = 0;
  int wr_n    = 0;
  bit no_resp = 1'b0;
  int done_cnt = 0;
  bit bb_err = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] peek_ram(input bit [31:0] a);
    return ram.exists(a) ? ram[a] : {a, ~a};
  endfunction

  function automatic logic [63:0] peek_mdl(input bit [31:0] a);
    return mdl.exists(a) ? mdl[a] : {a, ~a};
  endfunction

  // Reference copy: ascending doublewords, stop at the first faulted access.
  task automatic model(input vec_t v, output int cnt, output bit err);
    logic [31:0] ra, wa;
    logic [63:0] d;
    mdl = ram;
    exp_q.delete();
    cnt = 0;
    err = 1'b0;
    for (int i = 0; i < int'(v.len); i++) begin
      ra = {v.src[31:3], 3'b000} + 32'(8 * i);
      wa = {v.dst[31:3], 3'b000} + 32'(8 * i);
      exp_q.push_back('{a: ra, s: 8'h00, d: 64'h0});
      if (i + 1 == v.err_rd) begin err = 1'b1; break; end
      d = peek_mdl(ra);
      exp_q.push_back('{a: wa, s: 8'hFF, d: d});
      if (i + 1 == v.err_wr) begin err = 1'b1; break; end
      mdl[wa] = d;
      cnt++;
    end
  endtask

  // Bus monitor: log every request, flag back-to-back valid, count done pulses.
  initial begin
    bit prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (mif.mem_out.mem_valid) begin
          if (prev_v) bb_err = 1'b1;
          act_q.push_back('{a: mif.mem_out.mem_addr, s: mif.mem_out.mem_wstrb,
                            d: mif.mem_out.mem_wdata});
        end
        prev_v = mif.mem_out.mem_valid;
        if (done) done_cnt++;
      end else begin
        prev_v = 1'b0;
      end
    end
  end

  // RAM responder: ready comes rsp_lat cycles after the request cycle.
  initial begin
    logic [31:0] a;
    logic [7:0]  s;
    logic [63:0] d;
    bit          er;
    mif.mem_in = '0;
    @(negedge clock);
    forever begin
      if (mif.mem_out.mem_valid && !reset && !no_resp) begin
        a = mif.mem_out.mem_addr;
        s = mif.mem_out.mem_wstrb;
        d = mif.mem_out.mem_wdata;
        repeat (rsp_lat) @(negedge clock);
        if (s == 8'h00) begin
          rd_n++;
          er = (rd_n == err_rd);
          mif.mem_in.mem_rdata = er ? 64'h0 : peek_ram(a);
        end else begin
          wr_n++;
          er = (wr_n == err_wr);
          if (!er) ram[a] = d;
          mif.mem_in.mem_rdata = 64'h0;
        end
        mif.mem_in.mem_error = er;
        mif.mem_in.mem_ready = 1'b1;
        @(negedge clock);
        mif.mem_in = '0;
      end else begin
        @(negedge clock);
      end
    end
  end

  task automatic run_copy(input string nm, input vec_t v);
    int  mcnt, cyc, nbad;
    bit  merr, fin;
    model(v, mcnt, merr);
    rsp_lat = v.lat;
    err_rd  = v.err_rd;
    err_wr  = v.err_wr;
    rd_n    = 0;
    wr_n    = 0;
    if (v.extra) begin
      // Stray response while idle must be dropped.
      @(negedge clock);
      mif.mem_in.mem_ready = 1'b1;
      mif.mem_in.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clock);
      mif.mem_in = '0;
    end
    @(negedge clock);
    act_q.delete();
    done_cnt = 0;
    bb_err   = 1'b0;
    src_addr = v.src;
    dst_addr = v.dst;
    length   = v.len;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    fin   = 1'b0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (done || error) begin fin = 1'b1; break; end
      if (v.extra && cyc == 6) begin
        start = 1'b1; src_addr = 32'h9000; length = 16'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
    chk({nm, "_finished"}, fin, 1'b1);
    if (v.len == 16'd0) chk({nm, "_len0_latency"}, (cyc <= 1), 1'b1);
    repeat (3) @(negedge clock);
    chk({nm, "_done_pulses"}, done_cnt, v.exp_err ? 0 : 1);
    chk({nm, "_error"}, error, v.exp_err);
    chk({nm, "_count"}, count, v.exp_cnt);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_valid_pulses"}, act_q.size(), exp_q.size());
    nbad = 0;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      if (act_q[i] !== exp_q[i]) nbad++;
    chk({nm, "_access_log"}, nbad, 0);
    chk({nm, "_back_to_back"}, bb_err, 1'b0);
    for (int i = 0; i < int'(v.len); i++) begin
      logic [31:0] wa;
      wa = {v.dst[31:3], 3'b000} + 32'(8 * i);
      chk($sformatf("%s_dst%0d", nm, i), peek_ram(wa), peek_mdl(wa));
    end
  endtask

  vec_t vecs[10];

  initial begin
    vec_t rv;
    int   cyc;

    vecs[0] = '{32'h100, 32'h200, 16'd4, 17, 0, 0, 1'b0, 4, 1'b0};
    vecs[1] = '{32'h100, 32'h200, 16'd4, 17, 0, 0, 1'b1, 4, 1'b0};
    vecs[2] = '{32'h0,   32'h500, 16'd0, 1,  0, 0, 1'b0, 0, 1'b0};
    vecs[3] = '{32'h107, 32'h3FF, 16'd1, 3,  0, 0, 1'b0, 1, 1'b0};
    vecs[4] = '{32'hFFFF_FFF8, 32'h800, 16'd2, 2, 0, 0, 1'b0, 2, 1'b0};
    vecs[5] = '{32'h1000, 32'h2000, 16'd3, 4, 0, 2, 1'b0, 1, 1'b1};
    vecs[6] = '{32'h1000, 32'h2000, 16'd3, 4, 0, 0, 1'b0, 3, 1'b0};
    vecs[7] = '{32'h3000, 32'h4000, 16'd2, 1, 1, 0, 1'b0, 0, 1'b1};
    vecs[8] = '{32'h5000, 32'h5008, 16'd3, 1, 0, 0, 1'b0, 3, 1'b0};
    vecs[9] = '{32'h6000, 32'h7000, 16'd1, 32, 0, 0, 1'b0, 1, 1'b0};

    ram[32'h100] = 64'h1111_1111_1111_1111;
    ram[32'h108] = 64'h2222_2222_2222_2222;
    ram[32'h110] = 64'h3333_3333_3333_3333;
    ram[32'h118] = 64'h4444_4444_4444_4444;

    // Reset values, with start asserted alongside reset.
    repeat (2) @(negedge clock);
    start = 1'b1;
    length = 16'd4;
    @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_count", count, 16'd0);
    chk("rst_mem_out", mif.mem_out, '0);
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_start_ignored", busy, 1'b0);

    for (int i = 0; i < 10; i++) run_copy($sformatf("vec%0d", i), vecs[i]);

    for (int r = 0; r < 6; r++) begin
      rv.src    = $urandom();
      rv.dst    = $urandom();
      rv.len    = 16'($urandom_range(1, 5));
      rv.lat    = $urandom_range(1, 6);
      rv.err_rd = 0;
      rv.err_wr = ($urandom_range(0, 2) == 0) ? $urandom_range(1, int'(rv.len)) : 0;
      rv.extra  = 1'b0;
      rv.exp_cnt = (rv.err_wr == 0) ? int'(rv.len) : rv.err_wr - 1;
      rv.exp_err = (rv.err_wr != 0);
      run_copy($sformatf("rnd%0d", r), rv);
    end

    // Reset while waiting for a read response.
    rsp_lat = 17; err_rd = 0; err_wr = 0;
    @(negedge clock);
    src_addr = 32'h100; dst_addr = 32'h200; length = 16'd4; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    chk("abort_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", mif.mem_out.mem_valid, 1'b0);
    chk("abort_count", count, 16'd0);
    reset = 1'b0;
    act_q.delete();
    done_cnt = 0;
    repeat (30) @(negedge clock);
    chk("abort_no_valid", act_q.size(), 0);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_error", error, 1'b0);

`ifdef MEM_COPY_TIMEOUT_EN
    // Responder silent: error after 32 waiting cycles.
    no_resp = 1'b1;
    @(negedge clock);
    act_q.delete();
    src_addr = 32'h100; dst_addr = 32'h200; length = 16'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (cyc = 0; cyc < 200; cyc++) begin
      if (error) break;
      @(negedge clock);
    end
    chk("tmo_cycle", cyc, 33);
    chk("tmo_error", error, 1'b1);
    chk("tmo_count", count, 16'd0);
    @(negedge clock);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_valid_pulses", act_q.size(), 1);
    no_resp = 1'b0;
    repeat (3) @(negedge clock);
    run_copy("tmo_recover", vecs[0]);
`else
    cyc = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_copy.md
Name: mem_copy

Overview:
- Initiator-side block on the mem_in_type/mem_out_type memory interface; drives the request side and consumes the response side of the on-chip RAM.
- Block-copy engine: on start, reads LENGTH 64-bit doublewords from src_addr and writes each to dst_addr in order.
- One outstanding access at a time.
- Sits between a control master and the RAM port. Used for memory initialisation and relocation without core involvement.

Parameters:
- TIMEOUT, 1024: maximum cycles to wait for mem_ready per access. Used only with MEM_COPY_TIMEOUT_EN.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle command pulse; ignored while busy=1
- src_addr  input  32  source byte address; bits [2:0] ignored, treated as 0
- dst_addr  input  32  destination byte address; bits [2:0] ignored, treated as 0
- length  input  16  number of doublewords to copy
- busy  output  1  high from cycle after accepted start until done/error
- done  output  1  one-cycle pulse on successful completion
- error  output  1  sticky abort flag; cleared by next accepted start or reset
- count  output  16  doublewords fully written so far
- mem_out  output  mem_in_type  request to RAM; uses mem_valid, mem_addr, mem_wdata, mem_wstrb; all other fields 0
- mem_in  input  mem_out_type  response from RAM; uses mem_ready, mem_rdata, mem_error

Behaviour:
- Reset values: mem_out='0, busy=0, done=0, error=0, count=0, state=IDLE. Reset mid-copy aborts the copy immediately; no further mem_valid is issued after the reset edge.
- All outputs are registered.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE, FAIL.
- IDLE:
  - start=1 latches src/dst (low 3 bits cleared) and length; clears count and error.
  - Goes to RD_REQ, or to DONE if length=0 (no memory access).
- RD_REQ: drives mem_valid=1, mem_addr=src, mem_wstrb=8'h00 for exactly one cycle; then RD_WAIT.
- RD_WAIT: mem_valid=0. Waits for mem_ready=1.
  - mem_error=1 -> FAIL.
  - Otherwise latches mem_rdata into a 64-bit buffer -> WR_REQ.
- WR_REQ: drives mem_valid=1, mem_addr=dst, mem_wdata=buffer, mem_wstrb=8'hFF for one cycle; then WR_WAIT.
- WR_WAIT: waits for mem_ready=1.
  - mem_error=1 -> FAIL.
  - Otherwise: count+1, src+8, dst+8 (modulo 2^32, wraps silently). Next state is DONE if the new count equals length, else RD_REQ.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- FAIL: error=1 (held), busy=0, count frozen -> IDLE.
- mem_ready is ignored outside RD_WAIT/WR_WAIT (stray or late responses are dropped). mem_rdata is sampled only in the RD_WAIT cycle where mem_ready=1.
- mem_valid is never asserted on two consecutive cycles; responder latency is arbitrary (≥1 cycle).
- start while busy=1: no effect. start in the same cycle as reset: reset wins.
- Overlapping src/dst ranges: copied strictly ascending, no overlap handling.

Optional Feature:
- MEM_COPY_TIMEOUT_EN defined:
  - A 32-bit wait counter clears on entry to RD_WAIT/WR_WAIT and increments each waiting cycle.
  - Reaching TIMEOUT without mem_ready -> FAIL, error=1.
  - A mem_ready arriving in the same cycle the counter reaches TIMEOUT counts as success.
- Not defined: no counter; the block waits indefinitely for mem_ready.

Test Plan:
- RAM model with 17-cycle latency; src=0x100, dst=0x200, length=4, src holds 0x11..,0x22..,0x33..,0x44.. -> dst 0x200..0x218 matches, count=4, single done pulse, error=0, exactly 8 mem_valid pulses, read wstrb=0x00, write wstrb=0xFF.
- length=0, start -> done pulse within 2 cycles, busy low, zero mem_valid pulses.
- src=0x107, dst=0x3FF, length=1 -> accesses at 0x100 and 0x3F8; src=0xFFFFFFF8, length=2 -> second read at 0x00000000.
- mem_error=1 on 2nd write response, length=3 -> error=1, count=1, no further mem_valid; next start clears error and copies normally.
- Second start pulsed while busy, plus stray mem_ready in IDLE -> both ignored, results as in scenario 1; reset asserted in RD_WAIT -> next cycle busy=0, mem_valid=0, count=0.
- MEM_COPY_TIMEOUT_EN, TIMEOUT=32, RAM never responds -> error=1 after 32 wait cycles; with responder latency 17 -> normal completion.
